// File: rtl/nfc_acg_arbiter.sv
// nfc_acg_arbiter: round-robin arbiter sharing one ACG bus among NAND command modules
module nfc_acg_arbiter #(
  parameter int NumberOfReq   = 4,
  parameter int IndexWidth    = 2,
  parameter int NumberOfWays  = 4,
  parameter int TimeoutCycles = 0
) (
  input  logic                                iSystemClock,
  input  logic                                iReset,
  input  logic [NumberOfReq-1:0]              iReq,
  input  logic [NumberOfReq-1:0]              iReqLastStep,
  output logic [NumberOfReq-1:0]              oGrant,
  output logic [IndexWidth-1:0]               oGrantIndex,
  output logic                                oBusy,
  output logic                                oTimeout,
  input  logic [8*NumberOfReq-1:0]            iReqACG_Command,
  input  logic [3*NumberOfReq-1:0]            iReqACG_CommandOption,
  input  logic [NumberOfWays*NumberOfReq-1:0] iReqACG_TargetWay,
  input  logic [16*NumberOfReq-1:0]           iReqACG_NumOfData,
  input  logic [NumberOfReq-1:0]              iReqACG_CASelect,
  input  logic [40*NumberOfReq-1:0]           iReqACG_CAData,
  output logic [8*NumberOfReq-1:0]            oReqACG_Ready,
  output logic [8*NumberOfReq-1:0]            oReqACG_LastStep,
  output logic [7:0]                          oACG_Command,
  output logic [2:0]                          oACG_CommandOption,
  output logic [NumberOfWays-1:0]             oACG_TargetWay,
  output logic [15:0]                         oACG_NumOfData,
  output logic                                oACG_CASelect,
  output logic [39:0]                         oACG_CAData,
  input  logic [7:0]                          iACG_Ready,
  input  logic [7:0]                          iACG_LastStep
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} stateType;
  stateType state, stateNext;
  logic [IndexWidth-1:0] rrPointer, pick, probe;
  logic found, lastStep, aborted, watchdog, releaseNow;
  logic [31:0] holdCount;
  // round-robin search starting just after the last served requester
  always_comb begin
    found = 1'b0;
    pick = '0;
    probe = '0;
    for (int k = 1; k <= NumberOfReq; k++) begin
      probe = IndexWidth'((int'(rrPointer) + k) % NumberOfReq);
      if (!found && iReq[probe]) begin
        found = 1'b1;
        pick = probe;
      end
    end
  end
  // next state and release causes; a watchdog release only counts when nothing else ended the grant
  always_comb begin
    lastStep = iReqLastStep[oGrantIndex];
    aborted = !iReq[oGrantIndex];
    watchdog = (TimeoutCycles != 0) && (holdCount == 32'(TimeoutCycles - 1));
    releaseNow = lastStep || aborted || watchdog;
    stateNext = (state == IDLE) ? (found ? GRANT : IDLE) : (state == GRANT) ? (releaseNow ? RELEASE : GRANT) : IDLE;
    oTimeout = (state == GRANT) && watchdog && !lastStep && !aborted;
  end
  // state register
  always_ff @(posedge iSystemClock) begin
    state <= iReset ? IDLE : stateNext;
  end
  // grant, pointer and saturating hold counter
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      oGrant <= '0;
      oGrantIndex <= '0;
      oBusy <= 1'b0;
      rrPointer <= IndexWidth'(NumberOfReq - 1);
      holdCount <= '0;
    end else begin
      if (state == IDLE && found) begin
        oGrant <= NumberOfReq'(1) << pick;
        oGrantIndex <= pick;
        oBusy <= 1'b1;
      end
      if (state == GRANT && stateNext == RELEASE) begin
        oGrant <= '0;
        oBusy <= 1'b0;
      end
      if (state == RELEASE) rrPointer <= oGrantIndex;
      holdCount <= (state == GRANT) ? holdCount + {31'd0, holdCount != '1} : '0;
    end
  end
  // steer the granted requester to the ACG and the ACG feedback back to it alone
  always_comb begin
    oACG_Command = 8'h00;
    oACG_CommandOption = 3'h0;
    oACG_TargetWay = '0;
    oACG_NumOfData = 16'h0000;
    oACG_CASelect = 1'b1;
    oACG_CAData = 40'h0;
    oReqACG_Ready = '0;
    oReqACG_LastStep = '0;
    if (oBusy) begin
      oACG_Command = iReqACG_Command[8*oGrantIndex +: 8];
      oACG_CommandOption = iReqACG_CommandOption[3*oGrantIndex +: 3];
      oACG_TargetWay = iReqACG_TargetWay[NumberOfWays*oGrantIndex +: NumberOfWays];
      oACG_NumOfData = iReqACG_NumOfData[16*oGrantIndex +: 16];
      oACG_CASelect = iReqACG_CASelect[oGrantIndex];
      oACG_CAData = iReqACG_CAData[40*oGrantIndex +: 40];
      oReqACG_Ready[8*oGrantIndex +: 8] = iACG_Ready;
      oReqACG_LastStep[8*oGrantIndex +: 8] = iACG_LastStep;
    end
  end
endmodule

// File: tb/tb_nfc_acg_arbiter.sv
// tb_nfc_acg_arbiter: directed table, corner sequences and randomized model check of the ACG arbiter
module tb_nfc_acg_arbiter;
  localparam int TO = 16;
  logic iSystemClock = 1'b0;
  logic iReset = 1'b1;
  logic [3:0] iReq = '0, iReqLastStep = '0;
  logic [3:0] oGrant;
  logic [1:0] oGrantIndex;
  logic oBusy, oTimeout;
  logic [31:0] iReqACG_Command;
  logic [11:0] iReqACG_CommandOption;
  logic [15:0] iReqACG_TargetWay;
  logic [63:0] iReqACG_NumOfData;
  logic [3:0] iReqACG_CASelect;
  logic [159:0] iReqACG_CAData;
  logic [31:0] oReqACG_Ready, oReqACG_LastStep;
  logic [7:0] oACG_Command;
  logic [2:0] oACG_CommandOption;
  logic [3:0] oACG_TargetWay;
  logic [15:0] oACG_NumOfData;
  logic oACG_CASelect;
  logic [39:0] oACG_CAData;
  logic [7:0] iACG_Ready = '0, iACG_LastStep = '0;
  int errors = 0, checks = 0;
  int mBusy, mG, mPtr, mHeld, mGap;

  nfc_acg_arbiter #(.NumberOfReq(4), .IndexWidth(2), .NumberOfWays(4), .TimeoutCycles(TO)) dut (
    .iSystemClock(iSystemClock), .iReset(iReset), .iReq(iReq), .iReqLastStep(iReqLastStep),
    .oGrant(oGrant), .oGrantIndex(oGrantIndex), .oBusy(oBusy), .oTimeout(oTimeout),
    .iReqACG_Command(iReqACG_Command), .iReqACG_CommandOption(iReqACG_CommandOption),
    .iReqACG_TargetWay(iReqACG_TargetWay), .iReqACG_NumOfData(iReqACG_NumOfData),
    .iReqACG_CASelect(iReqACG_CASelect), .iReqACG_CAData(iReqACG_CAData),
    .oReqACG_Ready(oReqACG_Ready), .oReqACG_LastStep(oReqACG_LastStep),
    .oACG_Command(oACG_Command), .oACG_CommandOption(oACG_CommandOption),
    .oACG_TargetWay(oACG_TargetWay), .oACG_NumOfData(oACG_NumOfData),
    .oACG_CASelect(oACG_CASelect), .oACG_CAData(oACG_CAData),
    .iACG_Ready(iACG_Ready), .iACG_LastStep(iACG_LastStep));

  always #5 iSystemClock = ~iSystemClock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic busy;
    logic [39:0] ca;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iSystemClock);
    #1;
  endtask

  task automatic doReset();
    iReset = 1'b1;
    iReq = '0;
    iReqLastStep = '0;
    tick();
    iReset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iReqACG_Command = {8'h13, 8'h12, 8'h11, 8'h10};
    iReqACG_CommandOption = {3'd4, 3'd3, 3'd2, 3'd1};
    iReqACG_TargetWay = {4'h8, 4'h4, 4'h2, 4'h1};
    iReqACG_NumOfData = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    iReqACG_CASelect = 4'b0000;
    iReqACG_CAData = {40'h80_00_00_00_03, 40'h60_00_00_00_00, 40'h40_00_00_00_01, 40'h20_00_00_00_00};
    tbl[0] = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 40'h0};
    tbl[1] = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 40'h20_00_00_00_00};
    tbl[2] = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 40'h20_00_00_00_00};
    tbl[3] = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 40'h0};
    tbl[4] = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 40'h0};
    tbl[5] = '{4'b0101, 4'b0000, 4'b0100, 1'b1, 40'h60_00_00_00_00};
    tbl[6] = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 40'h60_00_00_00_00};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 40'h0};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 40'h0};
    iACG_Ready = 8'hA5;
    tick();
    doReset();
    chk("rst_grant", 64'(oGrant), 64'h0);
    chk("rst_busy", 64'(oBusy), 64'h0);
    chk("rst_timeout", 64'(oTimeout), 64'h0);
    chk("rst_caselect", 64'(oACG_CASelect), 64'h1);
    chk("rst_command", 64'(oACG_Command), 64'h0);
    chk("rst_cadata", 64'(oACG_CAData), 64'h0);
    chk("rst_ready", 64'(oReqACG_Ready), 64'h0);
    iACG_Ready = 8'h00;

    for (int i = 0; i < 9; i++) begin
      iReq = tbl[i].req;
      iReqLastStep = tbl[i].last;
      #1;
      chk($sformatf("tbl%0d_grant", i), 64'(oGrant), 64'(tbl[i].grant));
      chk($sformatf("tbl%0d_busy", i), 64'(oBusy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_cadata", i), 64'(oACG_CAData), 64'(tbl[i].ca));
      chk($sformatf("tbl%0d_timeout", i), 64'(oTimeout), 64'h0);
      tick();
    end

    doReset();
    iReq = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 10 && !oBusy; n++) begin
        chk("rr_onehot", 64'($onehot0(oGrant)), 64'h1);
        tick();
      end
      chk("rr_granted", 64'(oBusy), 64'h1);
      chk($sformatf("rr%0d_index", k), 64'(oGrantIndex), 64'(k % 4));
      chk($sformatf("rr%0d_grant", k), 64'(oGrant), 64'(4'b0001 << (k % 4)));
      iReqLastStep = 4'b0001 << (k % 4);
      tick();
      iReqLastStep = '0;
    end
    iReq = '0;

    doReset();
    iReq = 4'b0010;
    tick();
    chk("back_grant", 64'(oGrant), 64'h2);
    iACG_Ready = 8'hFF;
    iACG_LastStep = 8'h08;
    #1;
    chk("back_ready", 64'(oReqACG_Ready), 64'h0000_FF00);
    chk("back_last", 64'(oReqACG_LastStep), 64'h0000_0800);
    iReq = '0;
    tick();
    chk("back_idle_ready", 64'(oReqACG_Ready), 64'h0);
    iACG_Ready = 8'h00;
    iACG_LastStep = 8'h00;
    tick();

    doReset();
    iReq = 4'b1100;
    tick();
    for (int c = 1; c <= TO; c++) begin
      chk($sformatf("to_c%0d_grant", c), 64'(oGrant), 64'h4);
      chk($sformatf("to_c%0d_timeout", c), 64'(oTimeout), 64'(c == TO));
      tick();
    end
    chk("to_rel_grant", 64'(oGrant), 64'h0);
    chk("to_rel_timeout", 64'(oTimeout), 64'h0);
    tick();
    chk("to_idle_grant", 64'(oGrant), 64'h0);
    tick();
    chk("to_next_grant", 64'(oGrant), 64'h8);
    iReq = '0;
    tick();
    tick();

    doReset();
    iReq = 4'b0001;
    tick();
    for (int c = 1; c < TO; c++) tick();
    iReqLastStep = 4'b0001;
    #1;
    chk("to_last_timeout", 64'(oTimeout), 64'h0);
    chk("to_last_busy", 64'(oBusy), 64'h1);
    tick();
    iReqLastStep = '0;
    chk("to_last_released", 64'(oBusy), 64'h0);
    iReq = '0;
    tick();

    doReset();
    iReq = 4'b1000;
    tick();
    chk("mid_grant", 64'(oGrant), 64'h8);
    chk("mid_index", 64'(oGrantIndex), 64'h3);
    tick();
    iReset = 1'b1;
    tick();
    chk("mid_rst_grant", 64'(oGrant), 64'h0);
    chk("mid_rst_busy", 64'(oBusy), 64'h0);
    chk("mid_rst_caselect", 64'(oACG_CASelect), 64'h1);
    chk("mid_rst_command", 64'(oACG_Command), 64'h0);
    iReset = 1'b0;
    tick();
    chk("mid_regrant", 64'(oGrant), 64'h8);

    doReset();
    iReq = 4'b0011;
    tick();
    chk("abort_grant", 64'(oGrant), 64'h1);
    iReq = 4'b0010;
    #1;
    chk("abort_timeout", 64'(oTimeout), 64'h0);
    tick();
    chk("abort_busy", 64'(oBusy), 64'h0);
    tick();
    chk("abort_idle", 64'(oGrant), 64'h0);
    tick();
    chk("abort_next", 64'(oGrant), 64'h2);

    doReset();
    mBusy = 0; mG = 0; mPtr = 3; mHeld = 0; mGap = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) iReq = 4'($urandom);
      iReqLastStep = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      iACG_Ready = 8'($urandom);
      iACG_LastStep = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        iReqACG_Command = $urandom;
        iReqACG_CommandOption = 12'($urandom);
        iReqACG_TargetWay = 16'($urandom);
        iReqACG_NumOfData = {$urandom, $urandom};
        iReqACG_CASelect = 4'($urandom);
        iReqACG_CAData = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      iReset = ($urandom_range(0, 499) == 0);
      #1;
      chk("rnd_grant", 64'(oGrant), mBusy ? 64'(4'b0001 << mG) : 64'h0);
      chk("rnd_busy", 64'(oBusy), 64'(mBusy));
      if (mBusy != 0) chk("rnd_index", 64'(oGrantIndex), 64'(mG));
      chk("rnd_timeout", 64'(oTimeout), 64'(mBusy != 0 && mHeld == TO - 1 && !iReqLastStep[mG] && iReq[mG]));
      chk("rnd_command", 64'(oACG_Command), mBusy ? 64'(iReqACG_Command[8*mG +: 8]) : 64'h0);
      chk("rnd_option", 64'(oACG_CommandOption), mBusy ? 64'(iReqACG_CommandOption[3*mG +: 3]) : 64'h0);
      chk("rnd_way", 64'(oACG_TargetWay), mBusy ? 64'(iReqACG_TargetWay[4*mG +: 4]) : 64'h0);
      chk("rnd_numdata", 64'(oACG_NumOfData), mBusy ? 64'(iReqACG_NumOfData[16*mG +: 16]) : 64'h0);
      chk("rnd_caselect", 64'(oACG_CASelect), mBusy ? 64'(iReqACG_CASelect[mG]) : 64'h1);
      chk("rnd_cadata", 64'(oACG_CAData), mBusy ? 64'(iReqACG_CAData[40*mG +: 40]) : 64'h0);
      chk("rnd_ready", 64'(oReqACG_Ready), mBusy ? 64'(32'(iACG_Ready) << (8*mG)) : 64'h0);
      chk("rnd_last", 64'(oReqACG_LastStep), mBusy ? 64'(32'(iACG_LastStep) << (8*mG)) : 64'h0);
      tick();
      if (iReset) begin
        mBusy = 0; mPtr = 3; mHeld = 0; mGap = 0;
      end else if (mBusy != 0) begin
        if (iReqLastStep[mG] || !iReq[mG] || mHeld == TO - 1) begin
          mBusy = 0; mPtr = mG; mGap = 1;
        end else mHeld++;
      end else if (mGap != 0) mGap = 0;
      else begin
        for (int k = 1; k <= 4 && mBusy == 0; k++) begin
          if (iReq[(mPtr + k) % 4]) begin
            mBusy = 1; mG = (mPtr + k) % 4; mHeld = 0;
          end
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nfc_acg_arbiter.md
Name: nfc_acg_arbiter

Overview:
- Shares the single atomic command generator (ACG) bus among up to NumberOfReq NAND command modules, such as erase, program, read and reset sequencers.
- Grants the bus to one requester at a time with round-robin fairness.
- Holds the grant until that requester signals its last step, then steers the ACG control outputs and the ready/last-step feedback to the granted requester only.
- Sits between the command-module layer and the ACG/PHY layer.

Parameters:
- NumberOfReq, 4: number of requesting command modules.
- IndexWidth, 2: width of the grant index; ceil(log2(NumberOfReq)), minimum 1.
- NumberOfWays, 4: number of NAND ways (target-way bitmask width).
- TimeoutCycles, 0: maximum cycles a grant may be held; 0 disables the watchdog.

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  reset, synchronous, active-high
- iReq  in  NumberOfReq  per-requester bus request, level, held until granted
- iReqLastStep  in  NumberOfReq  per-requester command-complete pulse
- oGrant  out  NumberOfReq  one-hot grant
- oGrantIndex  out  IndexWidth  index of the granted requester; valid when oBusy=1
- oBusy  out  1  a grant is active
- oTimeout  out  1  one-cycle pulse on watchdog release
- iReqACG_Command  in  8*NumberOfReq  packed, requester i in slice [8i+7:8i]
- iReqACG_CommandOption  in  3*NumberOfReq
- iReqACG_TargetWay  in  NumberOfWays*NumberOfReq
- iReqACG_NumOfData  in  16*NumberOfReq
- iReqACG_CASelect  in  NumberOfReq
- iReqACG_CAData  in  40*NumberOfReq
- oReqACG_Ready  out  8*NumberOfReq  per-requester ready feedback
- oReqACG_LastStep  out  8*NumberOfReq  per-requester last-step feedback
- oACG_Command  out  8  to the ACG
- oACG_CommandOption  out  3
- oACG_TargetWay  out  NumberOfWays
- oACG_NumOfData  out  16
- oACG_CASelect  out  1
- oACG_CAData  out  40
- iACG_Ready  in  8  from the ACG
- iACG_LastStep  in  8  from the ACG

Behaviour:
- Reset (synchronous, on iSystemClock when iReset=1):
  - state=IDLE; oGrant=0, oGrantIndex=0, oBusy=0, oTimeout=0.
  - RR pointer=NumberOfReq-1, so requester 0 has first priority.
  - Hold counter=0.
  - Reset mid-grant drops the grant on the same edge; the ACG outputs return to the idle vector immediately after.
- Idle vector: Command=0, CommandOption=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0.
- State machine:
  - IDLE: if iReq!=0, search from (pointer+1) mod NumberOfReq upward with wrap; the first set bit wins. Register oGrant, oGrantIndex and oBusy=1, then go to GRANT. Latency: request at edge t is granted at t+1.
  - GRANT: the grant is held. Go to RELEASE when any of these holds:
    - iReqLastStep[g]=1;
    - iReq[g]=0 (requester aborted);
    - TimeoutCycles!=0 and hold counter reaches TimeoutCycles-1. In this case oTimeout pulses 1 on the transition edge.
  - RELEASE: exactly one cycle. oGrant=0, oBusy=0, pointer<=g, hold counter cleared. Then go to IDLE.
  - Minimum gap between grants: LastStep at t gives RELEASE at t+1, IDLE at t+2, next grant at t+3.
- Hold counter: 32-bit. Increments each GRANT cycle, clears in IDLE and RELEASE, saturates.
- Forward mux (combinational from the registered grant):
  - oBusy=1: oACG_* equal requester g's slices.
  - Otherwise: oACG_* equal the idle vector.
- Back mux (combinational):
  - Granted slice: oReqACG_Ready=iACG_Ready and oReqACG_LastStep=iACG_LastStep.
  - All non-granted slices: 8'h00, so they can never see ACG ready.
- Requests and iReqLastStep from non-granted requesters are ignored. Requests arriving during GRANT wait; no preemption.
- If iReqLastStep[g] and iReq[g]=0 occur in the same cycle, it is a single release; oTimeout stays 0.
- If the watchdog fires on the same edge as iReqLastStep[g], this is a normal release and oTimeout stays 0.
- Only one bit of oGrant may be set at any time.
- With a single requester continuously requesting, it is regranted every 3 cycles of idle gap.

Test Plan:
- Reset, then iReq=4'b0101 → oGrant=4'b0001 one cycle later. Pulse iReqLastStep[0] → RELEASE, then oGrant=4'b0100 at t+3. oACG_CAData equals requester 2's slice, e.g. 40'h60_00_00_00_00.
- Hold iReq=4'b1111 through 8 grant/release cycles → grant order 0,1,2,3,0,1,2,3. Never two grant bits set.
- While granted to 1, set iACG_Ready=8'hFF and iACG_LastStep=8'h08 → only slice 1 of oReqACG_Ready/oReqACG_LastStep nonzero. Other slices read 8'h00.
- TimeoutCycles=16, grant 2, never pulse last step → oTimeout=1 for one cycle at the 16th GRANT cycle. oGrant=0 next cycle; the next grant goes to 3 if requesting.
- Grant 3, assert iReset for one cycle mid-command → oGrant=0, oBusy=0, oACG_CASelect=1, oACG_Command=0. With iReq=4'b1000 re-asserted, requester 3 is regranted.
- Grant 0 then deassert iReq[0] without a last step → abort release. oTimeout=0; the pointer moves so requester 1 is next.
